// File: rtl/pam_transmitter.sv
// PAM-N transmitter: a 31-chip m-sequence preamble followed by a fixed-length frame of
// PAM symbols unpacked MSB-first from AXI-stream words, one DA sample per clock.
module pam_transmitter #(
    parameter int unsigned AD_CVER_WIDTH  = 12,
    parameter int unsigned PAM_ORDER      = 4,
    parameter int unsigned LENGTH_DATA    = 1024,
    parameter int unsigned LENTGRH_M_SEQ  = 31,
    parameter int unsigned WIDTH_AXI_DATA = 32
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          s_axi_tvalid,
    output logic                          s_axi_tready,
    input  logic [WIDTH_AXI_DATA/8-1:0]   s_axi_tkeep,
    input  logic [WIDTH_AXI_DATA-1:0]     s_axi_tdata,
    input  logic                          s_axi_tlast,
    output logic [AD_CVER_WIDTH-1:0]      da_send_data,
    output logic                          da_send_valid,
    output logic                          underrun,
    output logic                          frame_err
);

    localparam int unsigned BPS    = $clog2(PAM_ORDER);
    localparam int unsigned SPW    = WIDTH_AXI_DATA / BPS;
    localparam int unsigned NWORDS = LENGTH_DATA / SPW;
    localparam int unsigned SYM_W  = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int unsigned WORD_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned STEP   = ((2 ** AD_CVER_WIDTH) - 1) / (PAM_ORDER - 1);

    localparam logic [SYM_W-1:0]  LAST_SYM  = SYM_W'(SPW - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NWORDS - 1);
    localparam logic [4:0]        LAST_CHIP = 5'(LENTGRH_M_SEQ - 1);
    localparam logic [4:0]        LFSR_SEED = 5'b11111;

    typedef enum logic [1:0] {StIdle, StPreamble, StData} state_e;

    state_e                    state_q, state_d;
    logic [4:0]                lfsr_q, lfsr_d;
    logic [4:0]                chip_cnt_q, chip_cnt_d;
    logic [SYM_W-1:0]          sym_cnt_q, sym_cnt_d;
    logic [WORD_W-1:0]         word_cnt_q, word_cnt_d;
    logic [WIDTH_AXI_DATA-1:0] shift_q, shift_d;
    logic [AD_CVER_WIDTH-1:0]  data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      underrun_q, underrun_d;

    logic                      ready;
    logic                      accept;
    logic [WORD_W-1:0]         next_word;
    logic [WIDTH_AXI_DATA-1:0] word_in;
    logic [4:0]                lfsr_step;
    logic                      unused_tkeep;

    assign unused_tkeep = ^s_axi_tkeep;

    function automatic logic [AD_CVER_WIDTH-1:0] level(input logic [BPS-1:0] sym);
        return AD_CVER_WIDTH'(32'(sym) * STEP);
    endfunction

    // x^5 + x^3 + 1, chip taken from bit 0
    assign lfsr_step = {lfsr_q[3] ^ lfsr_q[0], lfsr_q[4:1]};

    always_comb begin
        ready = 1'b0;
        if (state_q == StPreamble && chip_cnt_q == LAST_CHIP) begin
            ready = 1'b1;
        end
        if (state_q == StData && sym_cnt_q == LAST_SYM && word_cnt_q != LAST_WORD) begin
            ready = 1'b1;
        end
        accept    = ready & s_axi_tvalid;
        next_word = (state_q == StData) ? word_cnt_q + WORD_W'(1) : '0;
        // A starved request still consumes a word slot, filled with level-0 symbols
        word_in   = s_axi_tvalid ? s_axi_tdata : '0;
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        chip_cnt_d = chip_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        word_cnt_d = word_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        underrun_d = underrun_q | (ready & ~s_axi_tvalid);

        case (state_q)
            StIdle: begin
                data_d  = '0;
                valid_d = 1'b0;
                if (s_axi_tvalid) begin
                    state_d    = StPreamble;
                    data_d     = lfsr_q[0] ? '1 : '0;
                    valid_d    = 1'b1;
                    lfsr_d     = lfsr_step;
                    chip_cnt_d = '0;
                end
            end
            StPreamble: begin
                if (chip_cnt_q == LAST_CHIP) begin
                    state_d    = StData;
                    lfsr_d     = LFSR_SEED;
                    data_d     = level(word_in[WIDTH_AXI_DATA-1 -: BPS]);
                    shift_d    = word_in << BPS;
                    sym_cnt_d  = '0;
                    word_cnt_d = next_word;
                end else begin
                    data_d     = lfsr_q[0] ? '1 : '0;
                    lfsr_d     = lfsr_step;
                    chip_cnt_d = chip_cnt_q + 5'd1;
                end
            end
            StData: begin
                if (sym_cnt_q == LAST_SYM) begin
                    if (word_cnt_q == LAST_WORD) begin
                        state_d    = StIdle;
                        data_d     = '0;
                        valid_d    = 1'b0;
                        lfsr_d     = LFSR_SEED;
                        chip_cnt_d = '0;
                        sym_cnt_d  = '0;
                        word_cnt_d = '0;
                    end else begin
                        data_d     = level(word_in[WIDTH_AXI_DATA-1 -: BPS]);
                        shift_d    = word_in << BPS;
                        sym_cnt_d  = '0;
                        word_cnt_d = next_word;
                    end
                end else begin
                    data_d    = level(shift_q[WIDTH_AXI_DATA-1 -: BPS]);
                    shift_d   = shift_q << BPS;
                    sym_cnt_d = sym_cnt_q + SYM_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= StIdle;
            lfsr_q     <= LFSR_SEED;
            chip_cnt_q <= '0;
            sym_cnt_q  <= '0;
            word_cnt_q <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            chip_cnt_q <= chip_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            word_cnt_q <= word_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
        end
    end

    assign s_axi_tready  = ready;
    assign frame_err     = accept & (s_axi_tlast != (next_word == LAST_WORD));
    assign da_send_data  = data_q;
    assign da_send_valid = valid_q;
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_pam_transmitter.sv
// Directed bench for pam_transmitter: PAM-4 frames (nominal, back-to-back, early tlast,
// underrun, mid-frame reset) and a PAM-2 frame, all against hand-derived sample values.
module tb_pam_transmitter;

    logic        clk;
    logic        arst_n;
    logic        tvalid_a, tlast_a, tready_a, valid_a, under_a, ferr_a;
    logic        tvalid_b, tlast_b, tready_b, valid_b, under_b, ferr_b;
    logic [31:0] tdata_a, tdata_b;
    logic [3:0]  tkeep;
    logic [11:0] data_a, data_b;

    int n_vec;
    int n_miss;

    // Chips 0..30 of the x^5+x^3+1 sequence from seed 11111, chip 0 in the MSB
    logic [30:0] pre_bits;
    logic [11:0] lvl4 [4];

    pam_transmitter #(.PAM_ORDER(4)) dut_a (
        .clk           (clk),
        .arst_n        (arst_n),
        .s_axi_tvalid  (tvalid_a),
        .s_axi_tready  (tready_a),
        .s_axi_tkeep   (tkeep),
        .s_axi_tdata   (tdata_a),
        .s_axi_tlast   (tlast_a),
        .da_send_data  (data_a),
        .da_send_valid (valid_a),
        .underrun      (under_a),
        .frame_err     (ferr_a)
    );

    pam_transmitter #(.PAM_ORDER(2)) dut_b (
        .clk           (clk),
        .arst_n        (arst_n),
        .s_axi_tvalid  (tvalid_b),
        .s_axi_tready  (tready_b),
        .s_axi_tkeep   (tkeep),
        .s_axi_tdata   (tdata_b),
        .s_axi_tlast   (tlast_b),
        .da_send_data  (data_b),
        .da_send_valid (valid_b),
        .underrun      (under_b),
        .frame_err     (ferr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_a"}, 32'(data_a), 32'd0);
        check({tag, "_valid_a"}, 32'(valid_a), 32'd0);
        check({tag, "_ready_a"}, 32'(tready_a), 32'd0);
        check({tag, "_under_a"}, 32'(under_a), 32'd0);
        check({tag, "_ferr_a"}, 32'(ferr_a), 32'd0);
        check({tag, "_valid_b"}, 32'(valid_b), 32'd0);
    endtask

    // Entered with the DUT idle and tvalid already raised; runs 31 + 1024 samples and the
    // trailing idle sample, or stops at sample abort_k by pulling reset mid-cycle.
    task automatic run_frame(input bit sel, input int drop_slot, input int early_slot,
                             input int abort_k, input bit exp_under, input bit chain);
        int          spw, nw, hs, d, slot;
        bit          req, tv;
        logic [11:0] exp_data, gd;
        logic        gv, gr, gf, gu;
        spw = sel ? 32 : 16;
        nw  = sel ? 32 : 64;
        hs  = 0;
        for (int k = 0; k < 31 + 1024; k++) begin
            @(posedge clk);
            #2;
            if (k < 31) begin
                exp_data = pre_bits[30 - k] ? 12'd4095 : 12'd0;
            end else begin
                d    = k - 31;
                slot = d / spw + 1;
                if (slot == drop_slot) exp_data = 12'd0;
                else if (sel) exp_data = (d % 2 == 0) ? 12'd4095 : 12'd0;
                else exp_data = lvl4[d % 4];
            end
            gd = sel ? data_b : data_a;
            gv = sel ? valid_b : valid_a;
            check($sformatf("data[%0d]", k), 32'(gd), 32'(exp_data));
            check($sformatf("valid[%0d]", k), 32'(gv), 32'd1);
            if (k == abort_k) begin
                gu = sel ? under_b : under_a;
                check("under_before_abort", 32'(gu), 32'(exp_under));
                arst_n = 1'b0;
                #1;
                check_reset_outputs("async_rst");
                return;
            end
            req  = (k == 30) || (k >= 31 && (k - 31) % spw == spw - 1 && (k - 31) / spw < nw - 1);
            slot = (k < 31) ? 1 : (k - 31) / spw + 2;
            tv   = !(req && slot == drop_slot);
            if (sel) begin
                tvalid_b = tv;
                tlast_b  = req && (slot == early_slot || slot == nw);
            end else begin
                tvalid_a = tv;
                tlast_a  = req && (slot == early_slot || slot == nw);
            end
            #1;
            gr = sel ? tready_b : tready_a;
            gf = sel ? ferr_b : ferr_a;
            check($sformatf("tready[%0d]", k), 32'(gr), 32'(req));
            check($sformatf("frame_err[%0d]", k), 32'(gf),
                  32'(req && early_slot != 0 && slot == early_slot));
            if (gr && tv) hs++;
        end
        check("handshakes", 32'(hs), 32'(nw - ((drop_slot != 0) ? 1 : 0)));
        @(posedge clk);
        #2;
        gd = sel ? data_b : data_a;
        gv = sel ? valid_b : valid_a;
        gu = sel ? under_b : under_a;
        check("idle_data", 32'(gd), 32'd0);
        check("idle_valid", 32'(gv), 32'd0);
        check("underrun", 32'(gu), 32'(exp_under));
        if (sel) begin
            tvalid_b = chain;
            tlast_b  = 1'b0;
        end else begin
            tvalid_a = chain;
            tlast_a  = 1'b0;
        end
        #1;
        gr = sel ? tready_b : tready_a;
        check("idle_tready", 32'(gr), 32'd0);
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        pre_bits = 31'b11111_00110_10010_00010_10111_01100_0;
        lvl4     = '{12'd0, 12'd1365, 12'd2730, 12'd4095};
        arst_n   = 1'b0;
        tvalid_a = 1'b0;
        tlast_a  = 1'b0;
        tdata_a  = 32'h1B1B1B1B;
        tvalid_b = 1'b0;
        tlast_b  = 1'b0;
        tdata_b  = 32'hAAAAAAAA;
        tkeep    = 4'hF;
        #23;
        check_reset_outputs("reset");
        arst_n = 1'b1;
        @(posedge clk);
        #2;
        check("idle_after_rst_valid", 32'(valid_a), 32'd0);
        check("idle_after_rst_ready", 32'(tready_a), 32'd0);

        // Nominal frame chained straight into a second one
        tvalid_a = 1'b1;
        run_frame(1'b0, 0, 0, -1, 1'b0, 1'b1);
        run_frame(1'b0, 0, 0, -1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("idle_hold_valid", 32'(valid_a), 32'd0);

        // Early tlast on word 5
        tvalid_a = 1'b1;
        run_frame(1'b0, 0, 5, -1, 1'b0, 1'b0);

        // Starved request for word 10
        tvalid_a = 1'b1;
        run_frame(1'b0, 10, 0, -1, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        check("underrun_sticky", 32'(under_a), 32'd1);

        // Reset at DATA sample 500, then a fresh frame
        tvalid_a = 1'b1;
        run_frame(1'b0, 0, 0, 31 + 500, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("rst_hold");
        arst_n = 1'b1;
        #1;
        check("post_rst_valid", 32'(valid_a), 32'd0);
        check("post_rst_ready", 32'(tready_a), 32'd0);
        run_frame(1'b0, 0, 0, -1, 1'b0, 1'b0);

        // PAM-2 frame
        tvalid_b = 1'b1;
        run_frame(1'b1, 0, 0, -1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
